// File: rtl/shift_add_multiplier_pkg.sv
// Shared types for the radix-2 shift-and-add multiplier: command opcodes and FSM states.
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_START = 2'b01,
        OP_ABORT = 2'b10,
        OP_RSVD  = 2'b11
    } opcode_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

endpackage

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one shift-and-add step per clock, product after BW steps.
// Note: resetn is an active-high asynchronous reset despite its name.
module shift_add_multiplier #(
    parameter int BW = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [BW-1:0]   multiplier,
    input  logic [BW-1:0]   multiplicand,
    input  logic [1:0]      opcode,
    output logic [2*BW-1:0] result,
    output logic            ready
);
    import shift_add_multiplier_pkg::*;

    localparam int CW = $clog2(BW + 1);

    state_e        state;
    opcode_e       op;
    logic [BW:0]   a;
    logic [BW-1:0] q;
    logic [BW-1:0] m;
    logic [CW-1:0] cnt;

    logic [BW:0]   sum;
    logic [BW:0]   a_next;
    logic [BW-1:0] q_next;

    assign op = opcode_e'(opcode);

    // One partial-product step; the BW+1-bit accumulator keeps the adder carry,
    // which shifts down into the top of A.
    always_comb begin
        sum    = a + (q[0] ? {1'b0, m} : '0);
        a_next = {1'b0, sum[BW:1]};
        q_next = {sum[0], q[BW-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state  <= S_IDLE;
            a      <= '0;
            q      <= '0;
            m      <= '0;
            cnt    <= '0;
            result <= '0;
            ready  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (op == OP_START) begin
                        m     <= multiplicand;
                        q     <= multiplier;
                        a     <= '0;
                        cnt   <= CW'(BW);
                        ready <= 1'b0;
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (op == OP_ABORT) begin
                        ready <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        a   <= a_next;
                        q   <= q_next;
                        cnt <= cnt - CW'(1);
                        // Last step: publish the whole product at once.
                        if (cnt == CW'(1)) begin
                            result <= {a_next[BW-1:0], q_next};
                            ready  <= 1'b1;
                            state  <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (BW=4), hand-computed products.
module tb_shift_add_multiplier;
    import shift_add_multiplier_pkg::*;

    localparam int BW = 4;

    logic            clk;
    logic            resetn;
    logic [BW-1:0]   multiplier;
    logic [BW-1:0]   multiplicand;
    logic [1:0]      opcode;
    logic [2*BW-1:0] result;
    logic            ready;

    int checks   = 0;
    int failures = 0;

    shift_add_multiplier #(.BW(BW)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .opcode       (opcode),
        .result       (result),
        .ready        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive a command for exactly one rising edge; returns at the following falling edge.
    task automatic issue(input opcode_e op, input logic [3:0] mp, input logic [3:0] mc);
        opcode       = op;
        multiplier   = mp;
        multiplicand = mc;
        @(negedge clk);
        opcode = OP_NOP;
    endtask

    // Start a multiply and check exact latency, held result, and final product.
    // With poke set, a second start (3*3) is issued while busy and must be ignored.
    task automatic run_mul(input string tag, input logic [3:0] mp, input logic [3:0] mc,
                           input logic [7:0] expected, input logic [7:0] prev, input bit poke);
        issue(OP_START, mp, mc);
        check({tag, "_busy0"}, {7'd0, ready}, 8'd0);
        for (int i = 1; i < BW; i++) begin
            if (poke && i == 1) issue(OP_START, 4'd3, 4'd3);
            else @(negedge clk);
            check({tag, "_busy"}, {7'd0, ready}, 8'd0);
            check({tag, "_hold"}, result, prev);
        end
        @(negedge clk);
        check({tag, "_ready"}, {7'd0, ready}, 8'd1);
        check({tag, "_result"}, result, expected);
    endtask

    initial begin
        resetn       = 1'b1;
        opcode       = OP_NOP;
        multiplier   = '0;
        multiplicand = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 8'h00);
        check("rst_ready", {7'd0, ready}, 8'd1);
        resetn = 1'b0;

        // Abort and reserved opcodes are nops in IDLE.
        issue(OP_ABORT, 4'd7, 4'd6);
        check("nop_abort_ready", {7'd0, ready}, 8'd1);
        issue(OP_RSVD, 4'd7, 4'd6);
        check("nop_rsvd_ready", {7'd0, ready}, 8'd1);
        check("nop_result", result, 8'h00);

        // 7*6 with an ignored start (new operands 3*3) mid-operation.
        run_mul("m7x6", 4'd7, 4'd6, 8'h2A, 8'h00, 1'b1);
        // Back-to-back: start on the cycle right after ready rose.
        run_mul("m9x10", 4'd9, 4'd10, 8'h5A, 8'h2A, 1'b0);
        run_mul("m15x15", 4'd15, 4'd15, 8'hE1, 8'h5A, 1'b0);
        run_mul("m0x13", 4'd0, 4'd13, 8'h00, 8'hE1, 1'b0);
        run_mul("m13x0", 4'd13, 4'd0, 8'h00, 8'h00, 1'b0);
        run_mul("m1x15", 4'd1, 4'd15, 8'h0F, 8'h00, 1'b0);

        // Abort mid 9*10: idle on the next edge, previous product kept.
        issue(OP_START, 4'd9, 4'd10);
        check("abort_busy", {7'd0, ready}, 8'd0);
        issue(OP_ABORT, 4'd9, 4'd10);
        check("abort_ready", {7'd0, ready}, 8'd1);
        check("abort_result", result, 8'h0F);
        repeat (BW) @(negedge clk);
        check("abort_stay_ready", {7'd0, ready}, 8'd1);
        check("abort_stay_result", result, 8'h0F);

        // Reset pulse mid-operation takes effect immediately.
        issue(OP_START, 4'd15, 4'd15);
        @(negedge clk);
        check("rstmid_busy", {7'd0, ready}, 8'd0);
        resetn = 1'b1;
        #1;
        check("rstmid_result", result, 8'h00);
        check("rstmid_ready", {7'd0, ready}, 8'd1);
        @(negedge clk);
        resetn = 1'b0;
        run_mul("m5x5", 4'd5, 4'd5, 8'h19, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
